// File: rtl/debounce_pulse.sv
// Push-button conditioner: two-flop synchroniser followed by a counter-driven
// debounce FSM producing a clean level and one-cycle press/release pulses.
module debounce_pulse #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic Clk,
  input  logic Reset,
  input  logic BtnIn,
  output logic Level,
  output logic PressPulse,
  output logic ReleasePulse
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    CHK_PRESS   = 2'd1,
    PRESSED     = 2'd2,
    CHK_RELEASE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_reg;
  logic             sync0_reg;
  logic             sync1_reg;
  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync0_reg    <= 1'b0;
      sync1_reg    <= 1'b0;
      cnt_reg      <= '0;
      state_reg    <= IDLE;
      Level        <= 1'b0;
      PressPulse   <= 1'b0;
      ReleasePulse <= 1'b0;
    end else begin
      sync0_reg    <= BtnIn;
      sync1_reg    <= sync0_reg;
      // Pulses last exactly one cycle; only the accepting transition re-raises them.
      PressPulse   <= 1'b0;
      ReleasePulse <= 1'b0;
      case (state_reg)
        IDLE: begin
          Level <= 1'b0;
          if (sync1_reg) begin
            state_reg <= CHK_PRESS;
            cnt_reg   <= CNT_ONE;
          end else begin
            cnt_reg <= '0;
          end
        end
        CHK_PRESS: begin
          if (!sync1_reg) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
          end else if (cnt_reg == CNT_LAST) begin
            state_reg  <= PRESSED;
            Level      <= 1'b1;
            PressPulse <= 1'b1;
            cnt_reg    <= '0;
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end
        PRESSED: begin
          Level <= 1'b1;
          if (!sync1_reg) begin
            state_reg <= CHK_RELEASE;
            cnt_reg   <= CNT_ONE;
          end
        end
        CHK_RELEASE: begin
          if (sync1_reg) begin
            state_reg <= PRESSED;
            cnt_reg   <= '0;
          end else if (cnt_reg == CNT_LAST) begin
            state_reg    <= IDLE;
            Level        <= 1'b0;
            ReleasePulse <= 1'b1;
            cnt_reg      <= '0;
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end
        default: begin
          state_reg <= IDLE;
          Level     <= 1'b0;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

endmodule
